// File: rtl/gcd_func.sv
// gcd_func: binary (Stein) GCD responder on the start/ready/done call handshake.
// Defining GCD_FUNC_CYCLE_COUNT_EN adds the 16-bit __func_cycles busy counter.
module gcd_func #(
    parameter int WIDTH = 32,
    parameter int KW    = 6
) (
    input  logic             __func_clock,
    input  logic             __func_reset,
    input  logic             __func_start,
    output logic             __func_ready,
    output logic             __func_done,
    input  logic [WIDTH-1:0] __args_a,
    input  logic [WIDTH-1:0] __args_b,
    output logic [WIDTH-1:0] __func_result
`ifdef GCD_FUNC_CYCLE_COUNT_EN
    ,
    output logic [15:0]      __func_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ALIGN,
        REDUCE,
        FIN
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a_nx;
    logic [WIDTH-1:0] b_nx;
    logic [WIDTH-1:0] result_nx;
    logic [KW-1:0]    k;
    logic [KW-1:0]    k_nx;
    logic             done_nx;
    logic             accept;

    assign __func_ready = (state == IDLE);
    assign accept       = __func_start && __func_ready;

    always_ff @(posedge __func_clock) begin
        if (__func_reset) begin
            state         <= IDLE;
            a             <= '0;
            b             <= '0;
            k             <= '0;
            __func_result <= '0;
            __func_done   <= 1'b0;
        end else begin
            state         <= state_nx;
            a             <= a_nx;
            b             <= b_nx;
            k             <= k_nx;
            __func_result <= result_nx;
            __func_done   <= done_nx;
        end
    end

    // done is registered out of FIN, so its pulse lands in the first IDLE cycle
    always_comb begin
        state_nx  = state;
        a_nx      = a;
        b_nx      = b;
        k_nx      = k;
        result_nx = __func_result;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    a_nx     = __args_a;
                    b_nx     = __args_b;
                    k_nx     = '0;
                    state_nx = INIT;
                end
            end
            INIT: begin
                if (a == '0) begin
                    result_nx = b;
                    state_nx  = FIN;
                end else if (b == '0) begin
                    result_nx = a;
                    state_nx  = FIN;
                end else if (a == b) begin
                    result_nx = a;
                    state_nx  = FIN;
                end else begin
                    state_nx = ALIGN;
                end
            end
            ALIGN: begin
                if (!a[0] && !b[0]) begin
                    a_nx = a >> 1;
                    b_nx = b >> 1;
                    k_nx = k + 1'b1;
                end else begin
                    state_nx = REDUCE;
                end
            end
            REDUCE: begin
                if (a == b) begin
                    result_nx = a << k;
                    state_nx  = FIN;
                end else if (!a[0]) begin
                    a_nx = a >> 1;
                end else if (!b[0]) begin
                    b_nx = b >> 1;
                end else if (a > b) begin
                    a_nx = (a - b) >> 1;
                end else begin
                    b_nx = (b - a) >> 1;
                end
            end
            FIN: begin
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

`ifdef GCD_FUNC_CYCLE_COUNT_EN
    logic [15:0] cycles;

    always_ff @(posedge __func_clock) begin
        if (__func_reset) begin
            cycles <= '0;
        end else if (accept) begin
            cycles <= '0;
        end else if (!__func_ready && cycles != 16'hFFFF) begin
            cycles <= cycles + 16'd1;
        end
    end

    assign __func_cycles = cycles;
`endif

endmodule

// File: tb/tb_gcd_func.sv
// tb_gcd_func: scoreboard bench for gcd_func call handshake and results.
// Define GCD_FUNC_CYCLE_COUNT_EN to also exercise __func_cycles.
module tb_gcd_func;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        ready;
    logic        done;
    logic [31:0] result;
`ifdef GCD_FUNC_CYCLE_COUNT_EN
    logic [15:0] cycles;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    gcd_func #(.WIDTH(32), .KW(6)) dut (
        .__func_clock  (clk),
        .__func_reset  (rst),
        .__func_start  (start),
        .__func_ready  (ready),
        .__func_done   (done),
        .__args_a      (a_in),
        .__args_b      (b_in),
        .__func_result (result)
`ifdef GCD_FUNC_CYCLE_COUNT_EN
        ,
        .__func_cycles (cycles)
`endif
    );

    function automatic logic [31:0] ref_gcd(input logic [31:0] x,
                                            input logic [31:0] y);
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Drives one accepted start; returns #1 after the accepting edge.
    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL issue_ready: ready=%0b required 1", ready);
        end
        start = 1'b1;
        a_in  = x;
        b_in  = y;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int pulses = 0;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", ready);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b required 0", done);
        end
        checks++;
        if (result !== 32'd0) begin
            errors++;
            $display("FAIL reset_result: got %0h required 0", result);
        end
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL idle_no_done: got %0d pulses required 0", pulses);
        end
    endtask

    task automatic test_trivial;
        logic [31:0] ta[4] = '{32'd0, 32'd0, 32'd9, 32'd5};
        logic [31:0] tb[4] = '{32'd0, 32'd7, 32'd0, 32'd5};
        logic [31:0] exp;
        int          lat;
        bit          got;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(ref_gcd(ta[i], tb[i]));
            issue(ta[i], tb[i]);
            wait_done(lat, got);
            exp = sb.pop_front();
            checks++;
            if (!got || lat != 3) begin
                errors++;
                $display("FAIL trivial_lat[%0d]: got %0d done=%0b required 3",
                         i, lat, got);
            end
            checks++;
            if (result !== exp) begin
                errors++;
                $display("FAIL trivial_res[%0d]: got %0h required %0h",
                         i, result, exp);
            end
        end
    endtask

    task automatic test_general;
        logic [31:0] ga[5] = '{32'd48, 32'd18, 32'd17,
                               32'h80000000, 32'd1};
        logic [31:0] gb[5] = '{32'd18, 32'd48, 32'd13,
                               32'hC0000000, 32'hFFFFFFFF};
        logic [31:0] exp;
        logic [31:0] held;
        int          lat;
        bit          got;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(ref_gcd(ga[i], gb[i]));
            issue(ga[i], gb[i]);
            wait_done(lat, got);
            exp = sb.pop_front();
            checks++;
            if (!got || lat > 99) begin
                errors++;
                $display("FAIL gen_lat[%0d]: got %0d done=%0b required <=99",
                         i, lat, got);
            end
            checks++;
            if (result !== exp) begin
                errors++;
                $display("FAIL gen_res[%0d]: got %0h required %0h",
                         i, result, exp);
            end
            held = result;
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL gen_pulse[%0d]: done=%b required 0", i, done);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (result !== exp) begin
                errors++;
                $display("FAIL gen_hold[%0d]: got %0h required %0h",
                         i, result, held);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp;
        int          pulses = 0;
        int          lat;
        bit          got = 1'b0;
        sb.push_back(ref_gcd(32'd48, 32'd18));
        issue(32'd48, 32'd18);
        start = 1'b1;
        a_in  = 32'd100;
        b_in  = 32'd75;
        repeat (5) begin
            @(negedge clk);
            if (done) pulses++;
        end
        start = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                pulses++;
            end
        end
        exp = sb.pop_front();
        checks++;
        if (!got || result !== exp) begin
            errors++;
            $display("FAIL b2b_first: got %0d done=%0b required %0d",
                     result, got, exp);
        end
        sb.push_back(ref_gcd(32'd100, 32'd75));
        start = 1'b1;
        a_in  = 32'd100;
        b_in  = 32'd75;
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d required 1", pulses);
        end
        wait_done(lat, got);
        exp = sb.pop_front();
        checks++;
        if (!got || result !== exp) begin
            errors++;
            $display("FAIL b2b_second: got %0d done=%0b required %0d",
                     result, got, exp);
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] exp;
        int          pulses = 0;
        int          lat;
        bit          got;
        issue(32'hFFFFFFFE, 32'h7FFFFFFF);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || result !== 32'd0) begin
            errors++;
            $display("FAIL abort_state: ready=%b result=%0h required 1/0",
                     ready, result);
        end
        if (done) pulses++;
        repeat (120) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_done: got %0d pulses required 0", pulses);
        end
        sb.push_back(ref_gcd(32'd12, 32'd8));
        issue(32'd12, 32'd8);
        wait_done(lat, got);
        exp = sb.pop_front();
        checks++;
        if (!got || result !== exp) begin
            errors++;
            $display("FAIL abort_next: got %0d done=%0b required %0d",
                     result, got, exp);
        end
    endtask

`ifdef GCD_FUNC_CYCLE_COUNT_EN
    task automatic test_cycles;
        int lat;
        bit got = 1'b0;
        int busy = 0;
        issue(32'd0, 32'd7);
        wait_done(lat, got);
        checks++;
        if (!got || cycles !== 16'd2) begin
            errors++;
            $display("FAIL cyc_trivial: got %0d required 2", cycles);
        end
        got = 1'b0;
        issue(32'd48, 32'd18);
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (!ready) busy++;
            if (done) got = 1'b1;
        end
        checks++;
        if (!got || cycles !== 16'(busy)) begin
            errors++;
            $display("FAIL cyc_busy: got %0d required %0d", cycles, busy);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (cycles !== 16'(busy)) begin
            errors++;
            $display("FAIL cyc_hold: got %0d required %0d", cycles, busy);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_trivial;
        test_general;
        test_back_to_back;
        test_reset_abort;
`ifdef GCD_FUNC_CYCLE_COUNT_EN
        test_cycles;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
